sprite_craft_ctrl: RTL

- Parametrised successor to the player-craft block, with one instance per craft (player and enemy types).
- Holds the craft position and applies 8-direction clamped movement with a configurable step.
- Cycles N normal animation frames, then runs a hit-triggered destroy animation and a DEAD/respawn state machine.
- Generates the sprite ROM address for the VGA compositor and returns the selected frame's pixel. All logic runs on a single clock, and pixel requests are qualified by a strobe.

---
 rtl/sprite_craft_ctrl_pkg.sv | 24 ++
 rtl/sprite_craft_ctrl_anim_divider.sv | 37 +++
 rtl/sprite_craft_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_craft_ctrl_pkg.sv
// Shared types and constants for the sprite craft controller and its animation dividers.
package sprite_craft_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE = 2'd0,
      ST_DYING = 2'd1,
      ST_DEAD  = 2'd2
   } state_t;

   // Bit positions inside dir = {up, down, left, right}
   localparam int DIR_UP    = 3;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 1;
   localparam int DIR_RIGHT = 0;

   localparam int H_DISP_PX = 640;
   localparam int V_DISP_PX = 480;

   // Counter width that stays legal for a modulus of 1
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_craft_ctrl_anim_divider.sv
// Clock divider feeding a modulo-N frame counter; clr restarts both at frame 0.
module anim_divider
   import sprite_craft_ctrl_pkg::*;
#(
   parameter int DIV = 64,
   parameter int N   = 2,
   parameter int FW  = cnt_w(N)
) (
   input  logic          clk_run,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic          wrap,
   output logic [FW-1:0] frame
);

   localparam int CW = cnt_w(DIV);

   logic [CW-1:0] cnt;

   assign wrap = en && (cnt == CW'(DIV - 1));

   always_ff @(posedge clk_run) begin
      if (rst || clr) begin
         cnt   <= '0;
         frame <= '0;
      end else if (en) begin
         if (wrap) begin
            cnt   <= '0;
            frame <= (frame == FW'(N - 1)) ? '0 : frame + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sprite_craft_ctrl.sv
// One craft: clamped 8-way movement, alive/dying/dead lifecycle, frame animation
// and a 2-cycle sprite pixel path against an external 1-cycle ROM.
module sprite_craft_ctrl
   import sprite_craft_ctrl_pkg::*;
#(
   parameter int X_SIZE      = 102,
   parameter int Y_SIZE      = 126,
   parameter int H_DISP      = H_DISP_PX,
   parameter int V_DISP      = V_DISP_PX,
   parameter int POS_W       = 10,
   parameter int SPEED       = 1,
   parameter int DEF_X       = 269,
   parameter int DEF_Y       = 340,
   parameter int N_NORMAL    = 2,
   parameter int N_DESTROY   = 3,
   parameter int ANIM_DIV    = 64,
   parameter int DESTROY_DIV = 16,
   parameter int GRAY_W      = 4,
   parameter int ADDR_W      = 14
) (
   input  logic                  clk_run,
   input  logic                  rst,
   input  logic                  en_i,
   input  logic                  frame_tick_i,
   input  logic                  pix_en_i,
   input  logic [POS_W-1:0]      req_x_i,
   input  logic [POS_W-1:0]      req_y_i,
   input  logic                  move_en_i,
   input  logic [3:0]            dir_i,
   input  logic                  hit_i,
   input  logic                  respawn_i,
   output logic [ADDR_W-1:0]     rom_addr_o,
   input  logic [N_NORMAL*(1+GRAY_W)+N_DESTROY*GRAY_W-1:0] rom_data_i,
   output logic [POS_W-1:0]      x_pos_o,
   output logic [POS_W-1:0]      y_pos_o,
   output logic [1:0]            state_o,
   output logic                  dead_o,
   output logic [3*GRAY_W-1:0]   vga_rgb_o,
   output logic                  vga_alpha_o
);

   localparam int RW      = N_NORMAL*(1+GRAY_W) + N_DESTROY*GRAY_W;
   localparam int PIX_MAX = X_SIZE*Y_SIZE - 1;
   localparam int NFW     = cnt_w(N_NORMAL);
   localparam int DFW     = cnt_w(N_DESTROY);

   localparam logic [POS_W:0] SPD   = (POS_W+1)'(SPEED);
   localparam logic [POS_W:0] X_MAX = (POS_W+1)'(H_DISP - X_SIZE);
   localparam logic [POS_W:0] Y_MAX = (POS_W+1)'(V_DISP - Y_SIZE);

   state_t             state;
   logic [POS_W-1:0]   x, y, x_nxt, y_nxt;
   logic [POS_W:0]     x_sum, y_sum, x_end, y_end;
   logic [ADDR_W-1:0]  pcnt;
   logic               in_area, hit_d;
   logic               go_dying, go_alive;
   logic               nwrap_unused, dwrap;
   logic [NFW-1:0]     nframe;
   logic [DFW-1:0]     dframe;
   logic [GRAY_W:0]    nslice [N_NORMAL];
   logic [GRAY_W-1:0]  dslice [N_DESTROY];
   logic               sel_a;
   logic [GRAY_W-1:0]  sel_g;

   assign x_pos_o    = x;
   assign y_pos_o    = y;
   assign state_o    = state;
   assign rom_addr_o = pcnt;

   assign go_dying = en_i && hit_i && (state == ST_ALIVE);
   assign go_alive = en_i && respawn_i && (state == ST_DEAD);

   anim_divider #(.DIV(ANIM_DIV), .N(N_NORMAL), .FW(NFW)) u_norm (
      .clk_run (clk_run),
      .rst     (rst),
      .clr     (go_alive),
      .en      (en_i && (state == ST_ALIVE)),
      .wrap    (nwrap_unused),
      .frame   (nframe)
   );

   anim_divider #(.DIV(DESTROY_DIV), .N(N_DESTROY), .FW(DFW)) u_dest (
      .clk_run (clk_run),
      .rst     (rst),
      .clr     (go_dying),
      .en      (en_i && (state == ST_DYING)),
      .wrap    (dwrap),
      .frame   (dframe)
   );

   // One extra bit so the far edge of a sprite near the top of the range cannot wrap
   assign x_end   = {1'b0, x} + (POS_W+1)'(X_SIZE);
   assign y_end   = {1'b0, y} + (POS_W+1)'(Y_SIZE);
   assign in_area = pix_en_i
                 && ({1'b0, req_x_i} >= {1'b0, x}) && ({1'b0, req_x_i} < x_end)
                 && ({1'b0, req_y_i} >= {1'b0, y}) && ({1'b0, req_y_i} < y_end);

   always_ff @(posedge clk_run) begin
      if (rst) begin
         pcnt  <= '0;
         hit_d <= 1'b0;
      end else begin
         hit_d <= en_i && in_area;
         if (en_i) begin
            if (frame_tick_i)
               pcnt <= '0;
            else if (in_area && (pcnt != ADDR_W'(PIX_MAX)))
               pcnt <= pcnt + 1'b1;
         end
      end
   end

   // ROM word is MSB-first: normal {alpha,gray} slices, then destroy gray slices
   for (genvar i = 0; i < N_NORMAL; i++) begin : g_nsl
      assign nslice[i] = rom_data_i[RW-1-i*(GRAY_W+1) -: GRAY_W+1];
   end
   for (genvar j = 0; j < N_DESTROY; j++) begin : g_dsl
      assign dslice[j] = rom_data_i[RW-1-N_NORMAL*(GRAY_W+1)-j*GRAY_W -: GRAY_W];
   end

   always_comb begin
      sel_a = 1'b0;
      sel_g = '0;
      case (state)
         ST_ALIVE: begin
            sel_a = nslice[nframe][GRAY_W];
            sel_g = nslice[nframe][GRAY_W-1:0];
         end
         ST_DYING: begin
            sel_g = dslice[dframe];
            sel_a = |dslice[dframe];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_run) begin
      if (rst) begin
         vga_rgb_o   <= '0;
         vga_alpha_o <= 1'b0;
      end else if (en_i && hit_d) begin
         vga_rgb_o   <= {3{sel_g}};
         vga_alpha_o <= sel_a;
      end else begin
         vga_rgb_o   <= '0;
         vga_alpha_o <= 1'b0;
      end
   end

   // Opposing direction bits cancel per axis; the axes move independently
   always_comb begin
      x_nxt = x;
      y_nxt = y;
      x_sum = {1'b0, x} + SPD;
      y_sum = {1'b0, y} + SPD;
      if (dir_i[DIR_LEFT] && !dir_i[DIR_RIGHT])
         x_nxt = ({1'b0, x} >= SPD) ? x - SPD[POS_W-1:0] : '0;
      else if (dir_i[DIR_RIGHT] && !dir_i[DIR_LEFT])
         x_nxt = (x_sum > X_MAX) ? X_MAX[POS_W-1:0] : x_sum[POS_W-1:0];
      if (dir_i[DIR_UP] && !dir_i[DIR_DOWN])
         y_nxt = ({1'b0, y} >= SPD) ? y - SPD[POS_W-1:0] : '0;
      else if (dir_i[DIR_DOWN] && !dir_i[DIR_UP])
         y_nxt = (y_sum > Y_MAX) ? Y_MAX[POS_W-1:0] : y_sum[POS_W-1:0];
   end

   always_ff @(posedge clk_run) begin
      if (rst) begin
         state  <= ST_ALIVE;
         x      <= POS_W'(DEF_X);
         y      <= POS_W'(DEF_Y);
         dead_o <= 1'b0;
      end else if (en_i) begin
         case (state)
            ST_ALIVE: begin
               if (move_en_i) begin
                  x <= x_nxt;
                  y <= y_nxt;
               end
               if (hit_i) state <= ST_DYING;
            end
            ST_DYING: begin
               if (dwrap && (dframe == DFW'(N_DESTROY - 1))) begin
                  state  <= ST_DEAD;
                  dead_o <= 1'b1;
               end
            end
            ST_DEAD: begin
               if (respawn_i) begin
                  state  <= ST_ALIVE;
                  dead_o <= 1'b0;
                  x      <= POS_W'(DEF_X);
                  y      <= POS_W'(DEF_Y);
               end
            end
            default: begin
               state  <= ST_ALIVE;
               dead_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
